// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-controller bus, pipeline state in and register enables/clears out
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [4:0]  ex_rt;
  logic        ex_memtoreg;
  logic        ex_mc_op;
  logic        branch_taken;
  logic        debug_halt;
  logic        debug_step;
  logic        pc_le;
  logic        if_id_le;
  logic        id_ex_le;
  logic        ex_mem_le;
  logic        if_id_clear;
  logic        id_ex_clear;
  logic        ex_mem_clear;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rt, ex_memtoreg, ex_mc_op, branch_taken, debug_halt, debug_step,
    input  pc_le, if_id_le, id_ex_le, ex_mem_le, if_id_clear, id_ex_clear, ex_mem_clear, state, stall_cycles
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rt, ex_memtoreg, ex_mc_op, branch_taken, debug_halt, debug_step,
    output pc_le, if_id_le, id_ex_le, ex_mem_le, if_id_clear, id_ex_clear, ex_mem_clear, state, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / multi-cycle stall, branch flush and debug halt/step control
module pipe_hazard_ctrl #(
  parameter int MC_CYCLES = 4
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, MC_WAIT = 2'd1, HALT = 2'd2, STEP = 2'd3} state_t;
  state_t      st, nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] stall;
  logic        lu, eval, mc_stall, lu_stall, freeze, rel, br, pc_le, stall_inc;
  assign lu = bus.ex_memtoreg && bus.ex_rt != 5'd0 &&
              (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
  // Hazard priority is evaluated in RUN (unless halting) and in the single STEP cycle
  assign eval      = (st == RUN && !bus.debug_halt) || st == STEP;
  assign mc_stall  = (eval && bus.ex_mc_op) || (st == MC_WAIT && cnt != 4'd0);
  assign lu_stall  = eval && !bus.ex_mc_op && lu;
  assign freeze    = (st == RUN && bus.debug_halt) || st == HALT;
  assign rel       = st == MC_WAIT && cnt == 4'd0;
  assign br        = ((eval && !bus.ex_mc_op && !lu) || rel) && bus.branch_taken;
  assign stall_inc = !pc_le && st != HALT && !(st == RUN && bus.debug_halt);
  // State, multi-cycle countdown and saturating stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= RUN;
      cnt   <= 4'd0;
      stall <= 16'd0;
    end else begin
      st    <= nxt;
      cnt   <= cnt_nxt;
      stall <= stall + 16'((stall_inc && stall != 16'hFFFF) ? 1 : 0);
    end
  end
  // Next state: halt requests during a multi-cycle op wait for its release cycle
  always_comb begin
    nxt = st;
    unique case (st)
      RUN:     nxt = bus.debug_halt ? HALT : bus.ex_mc_op ? MC_WAIT : RUN;
      MC_WAIT: nxt = cnt != 4'd0 ? MC_WAIT : bus.debug_halt ? HALT : RUN;
      HALT:    nxt = bus.debug_step ? STEP : !bus.debug_halt ? RUN : HALT;
      STEP:    nxt = bus.ex_mc_op ? MC_WAIT : HALT;
      default: nxt = RUN;
    endcase
    cnt_nxt = (eval && bus.ex_mc_op) ? 4'(MC_CYCLES - 2) : (st == MC_WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
  end
  // Register enables and bubble clears; reset forces every register to load a bubble
  always_comb begin
    pc_le            = reset && !freeze && !mc_stall && !lu_stall;
    bus.pc_le        = pc_le;
    bus.if_id_le     = pc_le;
    bus.id_ex_le     = reset && !freeze && !mc_stall;
    bus.ex_mem_le    = reset && !freeze;
    bus.if_id_clear  = !reset || br;
    bus.id_ex_clear  = !reset || lu_stall;
    bus.ex_mem_clear = !reset || mc_stall;
    bus.state        = st;
    bus.stall_cycles = stall;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: randomized + directed scoreboard bench against a behavioural hazard model
module tb_pipe_hazard_ctrl;
  localparam int MC = 4;
  typedef struct packed {
    logic [6:0]  ctl;
    logic [1:0]  state;
    logic [15:0] stall;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  pipe_hazard_ctrl_if bus();
  pipe_hazard_ctrl #(.MC_CYCLES(MC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_halted, m_stepping;
  int   m_mc_rem, m_stall;
  function automatic exp_t observed();
    return {bus.pc_le, bus.if_id_le, bus.id_ex_le, bus.ex_mem_le,
            bus.if_id_clear, bus.id_ex_clear, bus.ex_mem_clear, bus.state, bus.stall_cycles};
  endfunction
  // Monitor: compare the DUT against the oldest pending expectation, mid-cycle
  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = observed();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle t=%0t: got le/clr=%b state=%0d stall=%h, expected le/clr=%b state=%0d stall=%h",
                 $time, a.ctl, a.state, a.stall, e.ctl, e.state, e.stall);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // Reference model: mode flags plus remaining multi-cycle occupancy; pushes one expectation per cycle
  task automatic step_cyc();
    logic pc, ifid, idex, exm, ic, idc, emc, lu;
    logic [1:0] st_enc;
    bit counted;
    if (!reset) begin
      q.push_back({7'b0000111, 2'd0, 16'd0});
      m_halted = 0; m_stepping = 0; m_mc_rem = 0; m_stall = 0;
    end else begin
      {pc, ifid, idex, exm, ic, idc, emc} = 7'b1111000;
      counted = 1;
      st_enc = m_mc_rem > 0 ? 2'd1 : m_stepping ? 2'd3 : m_halted ? 2'd2 : 2'd0;
      lu = bus.ex_memtoreg && bus.ex_rt != 0 &&
           (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
      if (m_mc_rem > 1) begin
        {pc, ifid, idex, emc} = 4'b0001;
        m_mc_rem--;
      end else if (m_mc_rem == 1) begin
        ic = bus.branch_taken;
        m_mc_rem = 0;
        m_halted = bus.debug_halt;
      end else if (m_halted && !m_stepping) begin
        {pc, ifid, idex, exm} = 4'b0000;
        counted = 0;
        if (bus.debug_step) m_stepping = 1;
        else if (!bus.debug_halt) m_halted = 0;
      end else if (!m_stepping && bus.debug_halt) begin
        {pc, ifid, idex, exm} = 4'b0000;
        counted = 0;
        m_halted = 1;
      end else begin
        if (bus.ex_mc_op) begin
          {pc, ifid, idex, emc} = 4'b0001;
          m_mc_rem = MC - 1;
        end else if (lu) begin
          {pc, ifid, idc} = 3'b001;
        end else if (bus.branch_taken) begin
          ic = 1;
        end
        m_stepping = 0;
      end
      q.push_back({pc, ifid, idex, exm, ic, idc, emc, st_enc, 16'(m_stall)});
      if (counted && !pc && m_stall < 65535) m_stall++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0; bus.ex_rt = 0; bus.ex_memtoreg = 0;
    bus.ex_mc_op = 0; bus.branch_taken = 0; bus.debug_halt = 0; bus.debug_step = 0;
  endtask
  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    step_cyc();
    reset = 1;
    bus.ex_memtoreg = 1; bus.ex_rt = 5; bus.id_rs = 5;
    step_cyc();
    idle_inputs();
    step_cyc();
    chk("load_use_stall_count", 32'(bus.stall_cycles), 32'd1);
    bus.ex_mc_op = 1;
    repeat (MC) step_cyc();
    bus.ex_mc_op = 0;
    chk("mc_stall_count", 32'(bus.stall_cycles), 32'd4);
    bus.ex_memtoreg = 1; bus.ex_rt = 7; bus.id_rt = 7; bus.id_uses_rt = 1; bus.branch_taken = 1;
    step_cyc();
    bus.ex_memtoreg = 0;
    step_cyc();
    idle_inputs();
    bus.debug_halt = 1;
    repeat (2) step_cyc();
    bus.debug_step = 1;
    step_cyc();
    bus.debug_step = 0;
    repeat (2) step_cyc();
    bus.debug_halt = 0;
    repeat (2) step_cyc();
    bus.ex_mc_op = 1;
    step_cyc();
    bus.ex_mc_op = 0;
    step_cyc();
    bus.debug_halt = 1;
    repeat (3) step_cyc();
    chk("halt_after_release", 32'(bus.state), 32'd2);
    bus.debug_halt = 0;
    step_cyc();
    bus.ex_mc_op = 1;
    step_cyc();
    bus.ex_mc_op = 0;
    #2;
    reset = 0;
    #1;
    chk("async_reset_state", 32'(bus.state), 32'd0);
    chk("async_reset_ctl", 32'({bus.pc_le, bus.if_id_le, bus.id_ex_le, bus.ex_mem_le,
                                bus.if_id_clear, bus.id_ex_clear, bus.ex_mem_clear}), 32'b0000111);
    step_cyc();
    reset = 1;
    step_cyc();
    for (int i = 0; i < 3000; i++) begin
      bus.id_rs        = 5'($urandom_range(0, 3));
      bus.id_rt        = 5'($urandom_range(0, 3));
      bus.ex_rt        = 5'($urandom_range(0, 3));
      bus.id_uses_rt   = 1'($urandom_range(0, 1));
      bus.ex_memtoreg  = $urandom_range(0, 2) == 0;
      bus.ex_mc_op     = $urandom_range(0, 9) == 0;
      bus.branch_taken = $urandom_range(0, 2) == 0;
      bus.debug_step   = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 14) == 0) bus.debug_halt = ~bus.debug_halt;
      reset = $urandom_range(0, 199) != 0;
      step_cyc();
    end
    idle_inputs();
    reset = 0;
    step_cyc();
    reset = 1;
    bus.ex_memtoreg = 1; bus.ex_rt = 3; bus.id_rs = 3;
    repeat (65540) step_cyc();
    chk("stall_saturation", 32'(bus.stall_cycles), 32'hFFFF);
    idle_inputs();
    step_cyc();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MC_CYCLES, default 4, EX occupancy in cycles of a multi-cycle ALU op; legal range 2..16.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-004 id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
REQ-005 id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-006 ex_rt  in  5  rt field held in ID_EX (instruction in EX).
REQ-007 ex_memtoreg  in  1  EX instruction is a load.
REQ-008 ex_mc_op  in  1  EX instruction is a multi-cycle ALU op.
REQ-009 branch_taken  in  1  branch resolved taken in ID this cycle.
REQ-010 debug_halt  in  1  level request to freeze the pipeline.
REQ-011 debug_step  in  1  single-cycle pulse; advance one cycle while halted.
REQ-012 pc_le, if_id_le, id_ex_le, ex_mem_le  out  1 each  load enables for PC and pipeline registers.
REQ-013 if_id_clear, id_ex_clear, ex_mem_clear  out  1 each  bubble insertion (register loads zero).
REQ-014 state  out  2  current FSM state encoding.
REQ-015 stall_cycles  out  16  saturating count of stalled cycles.

Function
REQ-016 States: RUN=0, MC_WAIT=1, HALT=2, STEP=3; outputs are combinational from state, cnt and inputs.
REQ-017 Load-use hazard (lu) = ex_memtoreg && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
REQ-018 Default output set ("advance"): all le=1, all clears=0.
REQ-019 RUN/STEP priority, highest first: ex_mc_op, lu, branch_taken, advance.
REQ-020 ex_mc_op in RUN/STEP: pc_le=if_id_le=id_ex_le=0, ex_mem_clear=1; cnt<=MC_CYCLES-2; next MC_WAIT.
REQ-021 lu (no ex_mc_op): pc_le=if_id_le=0, id_ex_clear=1, ex_mem_le=1; branch_taken ignored that cycle; state unchanged.
REQ-022 branch_taken (no ex_mc_op, no lu): advance plus if_id_clear=1.
REQ-023 debug_halt in RUN: HALT has priority over all hazards; outputs all le=0, clears=0; next HALT.
REQ-024 MC_WAIT with cnt!=0: same outputs as REQ-020; cnt decrements; ex_mc_op ignored.
REQ-025 MC_WAIT with cnt==0: release cycle, ex_mc_op ignored; branch_taken honoured (if_id_clear=1), otherwise advance; next HALT if debug_halt=1, else RUN.
REQ-026 debug_halt during MC_WAIT is deferred until release; the MC sequence is never cut short.
REQ-027 HALT: all le=0, all clears=0; debug_step=1 -> STEP; else debug_halt=0 -> RUN; else stay.
REQ-028 STEP: evaluates per REQ-019 for exactly one cycle; next HALT, or MC_WAIT if ex_mc_op.
REQ-029 EX occupancy of one multi-cycle op is exactly MC_CYCLES cycles, including the release cycle.
REQ-030 stall_cycles increments by 1 each cycle pc_le==0 and state!=HALT; saturates at 16'hFFFF.
REQ-031 Cycles in which RUN transitions to HALT (REQ-023) do not count.
REQ-032 id_rs, id_rt and ex_rt equal to 0 never produce a hazard.

Reset
REQ-033 While reset=0: state=RUN, cnt=0, stall_cycles=0.
REQ-034 While reset=0: all le=0, all clears=1.
REQ-035 Reset mid-MC_WAIT or mid-HALT aborts immediately; the first cycle after release is evaluated in RUN.

Verification
REQ-036 Load-use: ex_memtoreg=1, ex_rt=5, id_rs=5 -> one cycle pc_le=0, if_id_le=0, id_ex_clear=1; stall_cycles=1.
REQ-037 Multi-cycle with MC_CYCLES=4: ex_mc_op=1 held -> 3 stall cycles (ex_mem_clear=1), then release cycle with all le=1; stall_cycles=3.
REQ-038 Simultaneous lu=1 and branch_taken=1 -> stall per REQ-021, if_id_clear=0; branch_taken alone next cycle -> if_id_clear=1.
REQ-039 Halt/step: debug_halt=1 -> HALT with all le=0; debug_step pulse -> exactly one advance cycle, then HALT; debug_halt=0 -> RUN.
REQ-040 Halt during MC_WAIT: debug_halt set at cnt=1 -> release completes, then HALT.
REQ-041 Reset and saturation: reset=0 mid-MC_WAIT -> state=0 and clears=1 asynchronously; preset 16'hFFFE plus 3 stall cycles -> stall_cycles=16'hFFFF.
